// File: rtl/nidhogg_keys_pkg.sv
// Purpose : shared scan codes, command codes, held-key bit indices and parser types.
// Latency : n/a (constants and types only).
// Backpr. : n/a.
// Used by the PS/2 key scheduler and by the motion/sword datapaths that consume
// the player commands.
package nidhogg_keys_pkg;

  // PS/2 set-2 prefix and keyboard control bytes
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_RESEND  = 8'hFE;

  // Left player keys
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;

  // Right player keys (arrows are the same codes with or without E0)
  localparam logic [7:0] SC_ARR_L   = 8'h6B;
  localparam logic [7:0] SC_ARR_R   = 8'h74;
  localparam logic [7:0] SC_ARR_U   = 8'h75;
  localparam logic [7:0] SC_ARR_D   = 8'h72;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_ENTER   = 8'h5A;

  // Player command codes
  localparam logic [2:0] CMD_NONE       = 3'd0;
  localparam logic [2:0] CMD_LEFT       = 3'd1;
  localparam logic [2:0] CMD_RIGHT      = 3'd2;
  localparam logic [2:0] CMD_JUMP       = 3'd3;
  localparam logic [2:0] CMD_THROW      = 3'd4;
  localparam logic [2:0] CMD_SWORD_DOWN = 3'd5;
  localparam logic [2:0] CMD_SWORD_UP   = 3'd6;

  // Held-key vector bit positions: {throw,jump,down,up,right,left}
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_JUMP  = 4;
  localparam int KEY_THROW = 5;
  localparam int NUM_KEYS  = 6;

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

  typedef enum logic [1:0] {PS_IDLE, PS_BRK, PS_EXT, PS_EXT_BRK} parse_state_t;

  // Bytes the keyboard emits that are not key events
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == SC_ACK) || (b == SC_BAT_OK) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

  // E0 12 / E0 59 are the fake shifts some keyboards wrap around extended keys
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

endpackage

// File: rtl/player_key_state.sv
// Purpose : per-player held keys, one-shot jump/throw pending bits, last direction, tick encoder.
// Latency : make/break visible on held 1 cycle later; cmd registered on the tick cycle.
// Backpr. : none; every make/break strobe is absorbed in the cycle it arrives.
// Ports:
//   clk_50MHz, rst          clock, synchronous active-high reset
//   key_make/key_brk/key_code  decoded key event from the parser (one per cycle max)
//   tick, game_en           issue strobe and issue enable
//   cmd                     command issued at the last tick, held until the next
//   held                    {throw,jump,down,up,right,left}
module player_key_state
  import nidhogg_keys_pkg::*;
#(
  parameter logic [7:0] CODE_LEFT  = SC_A,
  parameter logic [7:0] CODE_RIGHT = SC_D,
  parameter logic [7:0] CODE_UP    = SC_W,
  parameter logic [7:0] CODE_DOWN  = SC_S,
  parameter logic [7:0] CODE_JUMP  = SC_SPACE,
  parameter logic [7:0] CODE_THROW = SC_LSHIFT
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                key_make,
  input  logic                key_brk,
  input  logic [7:0]          key_code,
  input  logic                tick,
  input  logic                game_en,
  output logic [2:0]          cmd,
  output logic [NUM_KEYS-1:0] held
);

  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] mk;
  logic [NUM_KEYS-1:0] bk;
  logic [2:0]          cmd_sel;
  logic                pend_jump;
  logic                pend_throw;
  logic                pend_jump_nxt;
  logic                pend_throw_nxt;
  dir_t                last_dir;
  dir_t                last_dir_nxt;

  always_comb begin
    key_hit             = '0;
    key_hit[KEY_LEFT]   = (key_code == CODE_LEFT);
    key_hit[KEY_RIGHT]  = (key_code == CODE_RIGHT);
    key_hit[KEY_UP]     = (key_code == CODE_UP);
    key_hit[KEY_DOWN]   = (key_code == CODE_DOWN);
    key_hit[KEY_JUMP]   = (key_code == CODE_JUMP);
    key_hit[KEY_THROW]  = (key_code == CODE_THROW);
    mk = key_make ? key_hit : '0;
    bk = key_brk  ? key_hit : '0;
  end

  // Priority encoder over the registered state, so a byte landing in the
  // tick cycle only counts toward the following tick.
  always_comb begin
    cmd_sel = CMD_NONE;
    if (held[KEY_LEFT] && held[KEY_RIGHT])
      cmd_sel = (last_dir == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT;
    else if (held[KEY_LEFT])
      cmd_sel = CMD_LEFT;
    else if (held[KEY_RIGHT])
      cmd_sel = CMD_RIGHT;
    else if (pend_jump)
      cmd_sel = CMD_JUMP;
    else if (pend_throw)
      cmd_sel = CMD_THROW;
    else if (held[KEY_DOWN])
      cmd_sel = CMD_SWORD_DOWN;
    else if (held[KEY_UP])
      cmd_sel = CMD_SWORD_UP;
  end

  // Pending bits arm only on a fresh press (typematic repeats see held=1).
  // A new press in the same cycle as the clear survives: set is OR-ed last.
  always_comb begin
    pend_jump_nxt  = pend_jump;
    pend_throw_nxt = pend_throw;
    if (tick && (!game_en || cmd_sel == CMD_JUMP))
      pend_jump_nxt = 1'b0;
    if (tick && (!game_en || cmd_sel == CMD_THROW))
      pend_throw_nxt = 1'b0;
    if (mk[KEY_JUMP] && !held[KEY_JUMP])
      pend_jump_nxt = 1'b1;
    if (mk[KEY_THROW] && !held[KEY_THROW])
      pend_throw_nxt = 1'b1;
  end

  // Releasing the direction that currently wins hands priority to the other
  // one if it is still down.
  always_comb begin
    last_dir_nxt = last_dir;
    if (mk[KEY_LEFT])
      last_dir_nxt = DIR_LEFT;
    else if (mk[KEY_RIGHT])
      last_dir_nxt = DIR_RIGHT;
    else if (bk[KEY_LEFT] && last_dir == DIR_LEFT && held[KEY_RIGHT])
      last_dir_nxt = DIR_RIGHT;
    else if (bk[KEY_RIGHT] && last_dir == DIR_RIGHT && held[KEY_LEFT])
      last_dir_nxt = DIR_LEFT;
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      held       <= '0;
      pend_jump  <= 1'b0;
      pend_throw <= 1'b0;
      last_dir   <= DIR_LEFT;
      cmd        <= CMD_NONE;
    end else begin
      held       <= (held | mk) & ~bk;
      pend_jump  <= pend_jump_nxt;
      pend_throw <= pend_throw_nxt;
      last_dir   <= last_dir_nxt;
      if (tick)
        cmd <= game_en ? cmd_sel : CMD_NONE;
    end
  end

endmodule

// File: rtl/ps2_key_scheduler.sv
// Purpose : parse PS/2 make/F0/E0 byte stream and issue one arbitrated command per player per tick.
// Latency : key event lands in held 1 cycle after rx_valid; commands change only on tick cycles.
// Backpr. : none; one byte per rx_valid strobe is consumed every cycle.
// Ports:
//   clk_50MHz, rst       clock, synchronous active-high reset
//   rx_byte, rx_valid    scan byte and 1-cycle strobe from PS2Receiver
//   game_en              0 freezes command issue (held tracking continues)
//   tick                 1-cycle pulse every TICK_DIV cycles
//   lp_cmd, rp_cmd       per-player command, updated on tick
//   lp_held, rp_held     per-player held keys {throw,jump,down,up,right,left}
module ps2_key_scheduler
  import nidhogg_keys_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int PREFIX_TO = 50000
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                game_en,
  output logic                tick,
  output logic [2:0]          lp_cmd,
  output logic [2:0]          rp_cmd,
  output logic [NUM_KEYS-1:0] lp_held,
  output logic [NUM_KEYS-1:0] rp_held
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int TOW = $clog2(PREFIX_TO + 1);

  parse_state_t   state;
  parse_state_t   state_nxt;
  logic [TW-1:0]  tick_cnt;
  logic [TOW-1:0] to_cnt;
  logic           key_make;
  logic           key_brk;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_50MHz) begin
    if (rst)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Counts idle cycles spent waiting for the byte after a prefix.
  always_ff @(posedge clk_50MHz) begin
    if (rst)
      to_cnt <= '0;
    else if (rx_valid || state == PS_IDLE)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst)
      state <= PS_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_make  = 1'b0;
    key_brk   = 1'b0;
    if (rx_valid) begin
      unique case (state)
        PS_IDLE: begin
          if (rx_byte == PFX_BRK)
            state_nxt = PS_BRK;
          else if (rx_byte == PFX_EXT)
            state_nxt = PS_EXT;
          else if (!is_ctrl_byte(rx_byte))
            key_make = 1'b1;
        end
        PS_EXT: begin
          if (rx_byte == PFX_BRK) begin
            state_nxt = PS_EXT_BRK;
          end else begin
            state_nxt = PS_IDLE;
            key_make  = !is_fake_shift(rx_byte);
          end
        end
        PS_BRK: begin
          state_nxt = PS_IDLE;
          key_brk   = 1'b1;
        end
        PS_EXT_BRK: begin
          state_nxt = PS_IDLE;
          key_brk   = !is_fake_shift(rx_byte);
        end
        default: state_nxt = PS_IDLE;
      endcase
    end else if (state != PS_IDLE && to_cnt == TOW'(PREFIX_TO - 1)) begin
      // Abandon a dangling prefix so a lost byte cannot turn the next make into a break.
      state_nxt = PS_IDLE;
    end
  end

  player_key_state #(
    .CODE_LEFT  (SC_A),
    .CODE_RIGHT (SC_D),
    .CODE_UP    (SC_W),
    .CODE_DOWN  (SC_S),
    .CODE_JUMP  (SC_SPACE),
    .CODE_THROW (SC_LSHIFT)
  ) u_lp (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .key_make  (key_make),
    .key_brk   (key_brk),
    .key_code  (rx_byte),
    .tick      (tick),
    .game_en   (game_en),
    .cmd       (lp_cmd),
    .held      (lp_held)
  );

  player_key_state #(
    .CODE_LEFT  (SC_ARR_L),
    .CODE_RIGHT (SC_ARR_R),
    .CODE_UP    (SC_ARR_U),
    .CODE_DOWN  (SC_ARR_D),
    .CODE_JUMP  (SC_RSHIFT),
    .CODE_THROW (SC_ENTER)
  ) u_rp (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .key_make  (key_make),
    .key_brk   (key_brk),
    .key_code  (rx_byte),
    .tick      (tick),
    .game_en   (game_en),
    .cmd       (rp_cmd),
    .held      (rp_held)
  );

endmodule
